// File: rtl/mpei_boot_pkg.sv
// Shared types and constants for the MCU boot loader.
//   boot_state_e   : boot sequencer states
//   FLASH_READ_CMD : SPI flash READ opcode
//   CMD_BITS       : length of one SPI transfer (opcode + 24-bit address)
//   le_word        : reorders a word received MSB-first into little-endian
package mpei_boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    DATA,
    WRITE,
    CHECK,
    ERROR,
    DONE
  } boot_state_e;

  localparam logic [7:0] FLASH_READ_CMD = 8'h03;
  localparam int         CMD_BITS       = 32;

  // First flash byte lands in bits [7:0], fourth in bits [31:24].
  function automatic logic [31:0] le_word(input logic [31:0] be);
    return {be[7:0], be[15:8], be[23:16], be[31:24]};
  endfunction

endpackage

// File: rtl/mpei_boot_spi_shift.sv
// 32-bit full-duplex SPI mode-0 shifter with its own SCK generator.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   start_i      : load tx_i and start a transfer (wins over a running one)
//   tx_i         : word shifted out MSB-first on mosi_o
//   miso_i       : sampled on the clk_i edge where SCK rises
//   rx_o         : word shifted in MSB-first
//   done_o       : high in the cycle whose closing edge drops SCK for the
//                  last time; rx_o is complete in that cycle
//   sck_o, mosi_o: SPI clock (idles low) and data out
module mpei_boot_spi_shift
  import mpei_boot_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] tx_i,
  input  logic        miso_i,
  output logic [31:0] rx_o,
  output logic        done_o,
  output logic        sck_o,
  output logic        mosi_o
);

  localparam int                 DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0]      DIV_LOAD = DW'(CLK_DIV - 1);
  localparam int                 BW       = $clog2(CMD_BITS);
  localparam logic [BW-1:0]      BIT_LAST = BW'(CMD_BITS - 1);

  logic          r_busy;
  logic          r_sck;
  logic [DW-1:0] r_div;
  logic [BW-1:0] r_bit;
  logic [31:0]   r_tx;
  logic [31:0]   r_rx;
  logic          w_tick;

  // Half-period timer: terminal count toggles SCK and reloads.
  assign w_tick = r_busy && (r_div == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_busy <= 1'b0;
      r_sck  <= 1'b0;
      r_div  <= '0;
      r_bit  <= '0;
      r_tx   <= '0;
      r_rx   <= '0;
    end else if (start_i) begin
      r_busy <= 1'b1;
      r_sck  <= 1'b0;
      r_div  <= DIV_LOAD;
      r_bit  <= BIT_LAST;
      r_tx   <= tx_i;
    end else if (r_busy) begin
      if (w_tick) begin
        r_div <= DIV_LOAD;
        r_sck <= ~r_sck;
        if (!r_sck) begin
          r_rx <= {r_rx[30:0], miso_i};
        end else begin
          // MOSI advances only as SCK falls, so it is stable across the rise.
          r_tx  <= {r_tx[30:0], 1'b0};
          r_bit <= r_bit - BW'(1);
          if (r_bit == '0) r_busy <= 1'b0;
        end
      end else begin
        r_div <= r_div - DW'(1);
      end
    end
  end

  assign done_o = w_tick && r_sck && (r_bit == '0);
  assign rx_o   = r_rx;
  assign sck_o  = r_sck;
  assign mosi_o = r_tx[31];

endmodule

// File: rtl/mpei_boot_loader.sv
// Boot sequencer: holds the core in reset, reads NWORD words from SPI flash
// with one continuous READ (0x03) and writes them into TCM, then releases the
// core. Optional macro BOOT_CHECKSUM_EN reads one extra word and compares it
// with the 32-bit sum of the loaded words; a mismatch keeps the core in reset.
// Ports:
//   clk_i, rst_i             : clock, asynchronous active-high reset
//   boot_en_i                : sampled in IDLE; 0 releases the core at once
//   spi_sck_o/csn_o/mosi_o/miso_i : SPI flash, mode 0
//   tcm_we_o/addr_o/wdata_o/ready_i : TCM write port, held until ready
//   core_rst_o               : core reset, high until the load completes
//   done_o, err_o            : sticky completion / checksum failure
//
// state | meaning
// IDLE  | first cycle after reset, decide boot or skip
// CMD   | shifting READ opcode + flash address
// DATA  | shifting in one word
// WRITE | TCM write pending, SPI paused with csn low
// CHECK | compare running sum with checksum word
// ERROR | checksum mismatch, core held
// DONE  | core released
module mpei_boot_loader
  import mpei_boot_pkg::*;
#(
  parameter int          NWORD      = 32,
  parameter int          TCM_AW     = 10,
  parameter logic [23:0] FLASH_BASE = 24'h000000,
  parameter int          CLK_DIV    = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              boot_en_i,
  output logic              spi_sck_o,
  output logic              spi_csn_o,
  output logic              spi_mosi_o,
  input  logic              spi_miso_i,
  output logic              tcm_we_o,
  output logic [TCM_AW-1:0] tcm_addr_o,
  output logic [31:0]       tcm_wdata_o,
  input  logic              tcm_ready_i,
  output logic              core_rst_o,
  output logic              done_o,
  output logic              err_o
);

  localparam logic [TCM_AW-1:0] LAST_ADDR = TCM_AW'(NWORD - 1);

  boot_state_e       r_state, w_next;
  logic              w_start;
  logic [31:0]       w_tx;
  logic [31:0]       w_rx;
  logic              w_spi_done;
  logic              w_last_word;
  logic              r_csn;
  logic              r_we;
  logic [TCM_AW-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_core_rst;
  logic              r_done;
`ifdef BOOT_CHECKSUM_EN
  logic              r_sum_phase;
  logic [31:0]       r_sum;
  logic [31:0]       r_chk;
  logic              r_err;
`endif

  assign w_last_word = (r_addr == LAST_ADDR);

  mpei_boot_spi_shift #(.CLK_DIV(CLK_DIV)) u_spi (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start_i(w_start),
    .tx_i   (w_tx),
    .miso_i (spi_miso_i),
    .rx_o   (w_rx),
    .done_o (w_spi_done),
    .sck_o  (spi_sck_o),
    .mosi_o (spi_mosi_o)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_tx    = '0;
    case (r_state)
      IDLE: begin
        if (boot_en_i) begin
          w_next  = CMD;
          w_start = 1'b1;
          w_tx    = {FLASH_READ_CMD, FLASH_BASE};
        end else begin
          w_next = DONE;
        end
      end
      CMD: begin
        if (w_spi_done) begin
          w_next  = DATA;
          w_start = 1'b1;
        end
      end
      DATA: begin
        if (w_spi_done) begin
`ifdef BOOT_CHECKSUM_EN
          w_next = r_sum_phase ? CHECK : WRITE;
`else
          w_next = WRITE;
`endif
        end
      end
      WRITE: begin
        if (tcm_ready_i) begin
`ifdef BOOT_CHECKSUM_EN
          // After the last data word the checksum word follows.
          w_next  = DATA;
          w_start = 1'b1;
`else
          if (w_last_word) begin
            w_next = DONE;
          end else begin
            w_next  = DATA;
            w_start = 1'b1;
          end
`endif
        end
      end
`ifdef BOOT_CHECKSUM_EN
      CHECK: w_next = (r_sum == r_chk) ? DONE : ERROR;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_csn       <= 1'b1;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_core_rst  <= 1'b1;
      r_done      <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      r_sum_phase <= 1'b0;
      r_sum       <= '0;
      r_chk       <= '0;
      r_err       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: if (boot_en_i) r_csn <= 1'b0;
        DATA: begin
          if (w_spi_done) begin
`ifdef BOOT_CHECKSUM_EN
            if (r_sum_phase) begin
              r_chk <= le_word(w_rx);
              r_csn <= 1'b1;
            end else begin
              r_we    <= 1'b1;
              r_wdata <= le_word(w_rx);
            end
`else
            r_we    <= 1'b1;
            r_wdata <= le_word(w_rx);
`endif
          end
        end
        WRITE: begin
          if (tcm_ready_i) begin
            r_we <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            r_sum <= r_sum + r_wdata;
            if (w_last_word) r_sum_phase <= 1'b1;
            else             r_addr      <= r_addr + TCM_AW'(1);
`else
            // Address stops at NWORD-1 so a full-size TCM never wraps.
            if (w_last_word) r_csn  <= 1'b1;
            else             r_addr <= r_addr + TCM_AW'(1);
`endif
          end
        end
        DONE: begin
          r_core_rst <= 1'b0;
          r_done     <= 1'b1;
        end
`ifdef BOOT_CHECKSUM_EN
        ERROR: r_err <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

  assign spi_csn_o   = r_csn;
  assign tcm_we_o    = r_we;
  assign tcm_addr_o  = r_addr;
  assign tcm_wdata_o = r_wdata;
  assign core_rst_o  = r_core_rst;
  assign done_o      = r_done;
`ifdef BOOT_CHECKSUM_EN
  assign err_o       = r_err;
`else
  assign err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_mpei_boot_loader.sv
module tb_mpei_boot_loader;

`ifdef BOOT_CHECKSUM_EN
  localparam int CSUM = 1;
`else
  localparam int CSUM = 0;
`endif

  typedef struct packed {
    bit              en;
    bit              sel;       // 0: NWORD=4/CLK_DIV=1, 1: NWORD=2/CLK_DIV=3
    int              stall;     // TCM address to stall on, -1 none
    bit              glitch;
    bit              csum_bad;
    logic [3:0][31:0] w;
    bit              exp_done;
    bit              exp_err;
    int              exp_lat;
    int              tol;
  } vec_t;

  logic clk_i;
  logic rst_a, rst_b;
  bit   sel;
  logic boot_en, miso, tcm_ready;

  logic a_sck, a_csn, a_mosi, a_we, a_core_rst, a_done, a_err;
  logic b_sck, b_csn, b_mosi, b_we, b_core_rst, b_done, b_err;
  logic [9:0]  a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata;

  logic t_sck, t_csn, t_mosi, t_we, t_core_rst, t_done, t_err;
  logic [9:0]  t_addr;
  logic [31:0] t_wdata;

  assign t_sck      = sel ? b_sck      : a_sck;
  assign t_csn      = sel ? b_csn      : a_csn;
  assign t_mosi     = sel ? b_mosi     : a_mosi;
  assign t_we       = sel ? b_we       : a_we;
  assign t_addr     = sel ? b_addr     : a_addr;
  assign t_wdata    = sel ? b_wdata    : a_wdata;
  assign t_core_rst = sel ? b_core_rst : a_core_rst;
  assign t_done     = sel ? b_done     : a_done;
  assign t_err      = sel ? b_err      : a_err;

  mpei_boot_loader #(.NWORD(4), .TCM_AW(10), .FLASH_BASE(24'h000000), .CLK_DIV(1)) dut_a (
    .clk_i(clk_i), .rst_i(rst_a), .boot_en_i(boot_en),
    .spi_sck_o(a_sck), .spi_csn_o(a_csn), .spi_mosi_o(a_mosi), .spi_miso_i(miso),
    .tcm_we_o(a_we), .tcm_addr_o(a_addr), .tcm_wdata_o(a_wdata), .tcm_ready_i(tcm_ready),
    .core_rst_o(a_core_rst), .done_o(a_done), .err_o(a_err));

  mpei_boot_loader #(.NWORD(2), .TCM_AW(10), .FLASH_BASE(24'h000000), .CLK_DIV(3)) dut_b (
    .clk_i(clk_i), .rst_i(rst_b), .boot_en_i(boot_en),
    .spi_sck_o(b_sck), .spi_csn_o(b_csn), .spi_mosi_o(b_mosi), .spi_miso_i(miso),
    .tcm_we_o(b_we), .tcm_addr_o(b_addr), .tcm_wdata_o(b_wdata), .tcm_ready_i(tcm_ready),
    .core_rst_o(b_core_rst), .done_o(b_done), .err_o(b_err));

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // flash / TCM model state
  logic [7:0]  fbytes [0:23];
  logic [31:0] tcm [0:3];
  bit          glitch_en;
  int          stall_addr, stall_cnt, stall_bad, we_hi;
  logic [31:0] stall_w;
  int          wr_cnt, first_addr;
  int          n_rise, rise_cnt, mosi_bad;
  logic [31:0] cmd_cap;
  int          run, hi_bad, lo_min, cur_div;
  logic        prev;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Flash: commands sampled on SCK rise, data driven on SCK fall after 32 bits.
  always @(posedge t_sck) begin
    n_rise++;
    if (!t_csn) begin
      if (rise_cnt < 32) cmd_cap = {cmd_cap[30:0], t_mosi};
      else if (t_mosi) mosi_bad++;
      rise_cnt++;
    end
  end

  always @(posedge t_csn) rise_cnt = 0;

  always @(negedge t_sck) begin
    if (!t_csn && rise_cnt >= 32) begin
      int k;
      logic b;
      k = rise_cnt - 32;
      b = (k / 8 < 24) ? fbytes[k / 8][7 - (k % 8)] : 1'b0;
      if (glitch_en) begin
        miso = ~b;
        @(posedge clk_i);
        #1 miso = b;
      end else begin
        miso = b;
      end
    end
  end

  // TCM handshake, stall injection and SCK phase-length monitor.
  always @(negedge clk_i) begin
    if (t_we && int'(t_addr) == stall_addr && stall_cnt < 5) begin
      tcm_ready = 1'b0;
      stall_cnt++;
      if (t_wdata !== stall_w || t_sck !== 1'b0) stall_bad++;
    end else begin
      tcm_ready = 1'b1;
    end
    if (t_we && int'(t_addr) == stall_addr) we_hi++;
    if (t_we && tcm_ready) begin
      tcm[t_addr[1:0]] = t_wdata;
      wr_cnt++;
      if (first_addr < 0) first_addr = int'(t_addr);
    end
    if (!t_csn) begin
      if (t_sck == prev) run++;
      else begin
        if (prev) begin
          if (run != cur_div) hi_bad++;
        end else if (run < lo_min) lo_min = run;
        run  = 1;
        prev = t_sck;
      end
    end
  end

  function automatic vec_t mk(input bit en, input bit s, input int stall, input bit gl,
                              input bit cb, input logic [3:0][31:0] w);
    vec_t v;
    int n, d;
    n = s ? 2 : 4;
    d = s ? 3 : 1;
    v.en = en; v.sel = s; v.stall = stall; v.glitch = gl; v.csum_bad = cb; v.w = w;
    v.exp_err  = en && cb && (CSUM != 0);
    v.exp_done = !v.exp_err;
    if (en) begin
      v.exp_lat = 2 * d * (32 + 32 * n) + n + 3 + ((stall >= 0) ? 5 : 0) + CSUM * (64 * d + 1);
      v.tol     = 4;
    end else begin
      v.exp_lat = 2;
      v.tol     = 1;
    end
    return v;
  endfunction

  task automatic setup(input vec_t v);
    int n;
    logic [31:0] sum;
    n   = v.sel ? 2 : 4;
    sum = 32'h0;
    for (int i = 0; i < n; i++) sum += v.w[i];
    if (v.csum_bad) sum += 32'h1;
    for (int i = 0; i < 24; i++) fbytes[i] = 8'h00;
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 4; b++) fbytes[4 * i + b] = v.w[i][8 * b +: 8];
    for (int b = 0; b < 4; b++) fbytes[4 * n + b] = sum[8 * b +: 8];
    rst_a = 1'b1; rst_b = 1'b1;
    sel = v.sel; boot_en = v.en; glitch_en = v.glitch;
    stall_addr = v.stall; stall_w = v.w[1]; cur_div = v.sel ? 3 : 1;
    miso = 1'b0;
    repeat (3) @(negedge clk_i);
    for (int i = 0; i < 4; i++) tcm[i] = 32'h0;
    wr_cnt = 0; first_addr = -1; stall_cnt = 0; stall_bad = 0; we_hi = 0;
    n_rise = 0; rise_cnt = 0; cmd_cap = 32'h0; mosi_bad = 0;
    run = 0; prev = 1'b0; hi_bad = 0; lo_min = 999;
  endtask

  task automatic wait_end(output int cyc);
    cyc = 0;
    while (!(t_done || t_err) && cyc < 6000) begin
      @(negedge clk_i);
      cyc++;
    end
    chk("finish_in_budget", 64'(cyc < 6000), 64'd1);
  endtask

  task automatic check_tcm(input vec_t v, input string tag);
    int n;
    n = v.sel ? 2 : 4;
    for (int i = 0; i < n; i++)
      chk({tag, "_tcm_word"}, tcm[i], v.en ? v.w[i] : 32'h0);
    chk({tag, "_write_count"}, wr_cnt, v.en ? n : 0);
  endtask

  task automatic run_vec(input vec_t v);
    int cyc, n, diff;
    n = v.sel ? 2 : 4;
    setup(v);
    chk("reset_state",
        {t_sck, t_csn, t_mosi, t_we, t_addr, t_wdata, t_core_rst, t_done, t_err},
        {1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0});
    if (v.sel) rst_b = 1'b0;
    else       rst_a = 1'b0;
    wait_end(cyc);
    chk("done", t_done, v.exp_done);
    chk("err", t_err, v.exp_err);
    chk("core_rst", t_core_rst, !v.exp_done);
    if (v.exp_done) begin
      diff = cyc - v.exp_lat;
      if (diff < 0) diff = -diff;
      chk("latency_window", 64'(diff <= v.tol), 64'd1);
    end
    repeat (4) @(negedge clk_i);
    chk("csn_idle_at_end", t_csn, 1'b1);
    check_tcm(v, "vec");
    chk("first_write_addr", first_addr, v.en ? 0 : -1);
    chk("cmd_word", cmd_cap, v.en ? 32'h03000000 : 32'h0);
    chk("sck_rises", n_rise, v.en ? 32 + 32 * (n + CSUM) : 0);
    chk("mosi_zero_in_data", mosi_bad, 0);
    if (v.en) begin
      chk("sck_high_len", hi_bad, 0);
      chk("sck_low_len", lo_min, cur_div);
    end
    if (v.stall >= 0) begin
      chk("stall_we_cycles", we_hi, 6);
      chk("stall_stable", stall_bad, 0);
    end
  endtask

  vec_t vecs [5];

  initial begin
    int cyc;
    logic [3:0][31:0] base_w, alt_w, div3_w;
    base_w = {32'hDDEEFF00, 32'h99AABBCC, 32'h55667788, 32'h11223344};
    alt_w  = {32'h0000FFFF, 32'hA5A5A5A5, 32'h01234567, 32'hDEADBEEF};
    div3_w = {32'h0, 32'h0, 32'h80000001, 32'hCAFEF00D};
    vecs[0] = mk(1'b1, 1'b0, -1, 1'b0, 1'b0, base_w);
    vecs[1] = mk(1'b1, 1'b0,  1, 1'b0, 1'b0, alt_w);
    vecs[2] = mk(1'b0, 1'b0, -1, 1'b0, 1'b0, base_w);
    vecs[3] = mk(1'b1, 1'b1, -1, 1'b1, 1'b0, div3_w);
    vecs[4] = mk(1'b1, 1'b0, -1, 1'b0, 1'b1, base_w);

    rst_a = 1'b1; rst_b = 1'b1; boot_en = 1'b0; miso = 1'b0; tcm_ready = 1'b1;
    sel = 1'b0; glitch_en = 1'b0; stall_addr = -1; stall_w = 32'h0; cur_div = 1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Reset in the middle of word 2, then a clean reload.
    setup(vecs[0]);
    rst_a = 1'b0;
    cyc = 0;
    while (!(t_addr == 10'd2 && !t_we) && cyc < 1000) begin
      @(negedge clk_i);
      cyc++;
    end
    repeat (20) @(negedge clk_i);
    chk("midload_position", {t_addr, t_csn, t_we}, {10'd2, 1'b0, 1'b0});
    #3 rst_a = 1'b1;
    #1;
    chk("midload_async_reset", {t_csn, t_core_rst, t_sck, t_we, t_addr, t_done},
        {1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 1'b0});
    repeat (2) @(negedge clk_i);
    for (int i = 0; i < 4; i++) tcm[i] = 32'h0;
    wr_cnt = 0; first_addr = -1;
    rst_a = 1'b0;
    wait_end(cyc);
    chk("reload_done", {t_done, t_core_rst}, {vecs[0].exp_done, !vecs[0].exp_done});
    chk("reload_first_addr", first_addr, 0);
    check_tcm(vecs[0], "reload");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
